booth_multiplier_param: RTL and testbench

Parametrised, sequential two's-complement/unsigned Booth multiplier with a start/busy/done handshake. It is the generalised successor to the fixed 8-bit Booth data path: operand width is a parameter, signedness is selectable, and an optional radix-4 recoding halves the iteration count. The block sits behind the start-synchronising interface logic and feeds `result` to downstream consumers on a one-cycle `done` strobe.

---
 rtl/booth_multiplier_param_if.sv | 30 +++
 rtl/booth_multiplier_param.sv | 161 ++++++++++++++++
 tb/tb_booth_multiplier_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_param_if.sv
// Handshake and operand/result bus of booth_multiplier_param.
// The requester drives start and the operands; the multiplier returns result, busy and done.
interface booth_multiplier_param_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   a_value;
    logic [WIDTH-1:0]   b_value;
    logic [2*WIDTH-1:0] result;
    logic               busy;
    logic               done;

    modport master (
        output start,
        output a_value,
        output b_value,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a_value,
        input  b_value,
        output result,
        output busy,
        output done
    );
endinterface

// File: rtl/booth_multiplier_param.sv
// Sequential Booth multiplier with parametrised width and selectable signedness, start/busy/done handshake.
// Defining BOOTH_RADIX4_EN selects radix-4 recoding, which halves the iteration count.
module booth_multiplier_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic                           clock,
    input  logic                           _reset,
    booth_multiplier_param_if.slave        bus
);
`ifdef BOOTH_RADIX4_EN
    localparam int RADIX4 = 1;
`else
    localparam int RADIX4 = 0;
`endif
    localparam int E  = (SIGNED != 0) ? 0 : ((RADIX4 != 0) ? 2 : 1);
    localparam int SH = (RADIX4 != 0) ? 2 : 1;
    localparam int PW = WIDTH + 2;
    localparam int QW = WIDTH + E;
    localparam int N  = (RADIX4 != 0) ? QW / 2 : QW;
    localparam int CW = $clog2(N + 1);
    localparam int SW = PW + SH;
    localparam int RW = 2 * WIDTH;

    generate
        if (WIDTH < 4) begin : g_width_too_small
            $error("booth_multiplier_param: WIDTH must be at least 4");
        end
        if ((RADIX4 != 0) && ((WIDTH % 2) != 0)) begin : g_width_odd
            $error("booth_multiplier_param: WIDTH must be even with BOOTH_RADIX4_EN");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   m_q, m_d;
    logic [PW-1:0]   p_q, p_d;
    logic [QW-1:0]   q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            a_msb_s;
    logic [SW-1:0]   p_ext_s;
    logic [SW-1:0]   m_ext_s;
    logic [SW-1:0]   sum_s;
    logic [RW-1:0]   prod_s;

    assign a_msb_s = (SIGNED != 0) ? bus.a_value[WIDTH-1] : 1'b0;

    // Booth recoding of the current multiplier digit and the add/subtract into the widened accumulator.
    // The sum carries SH extra bits so even +/-2M on top of a partial P cannot wrap before the shift.
    always_comb begin
        p_ext_s = {{SH{p_q[PW-1]}}, p_q};
        m_ext_s = {{SH{m_q[PW-1]}}, m_q};
        sum_s   = p_ext_s;
`ifdef BOOTH_RADIX4_EN
        case ({q_q[1], q_q[0], q1_q})
            3'b001, 3'b010: sum_s = p_ext_s + m_ext_s;
            3'b011:         sum_s = p_ext_s + {m_ext_s[SW-2:0], 1'b0};
            3'b100:         sum_s = p_ext_s - {m_ext_s[SW-2:0], 1'b0};
            3'b101, 3'b110: sum_s = p_ext_s - m_ext_s;
            default:        sum_s = p_ext_s;
        endcase
`else
        case ({q_q[0], q1_q})
            2'b01:   sum_s = p_ext_s + m_ext_s;
            2'b10:   sum_s = p_ext_s - m_ext_s;
            default: sum_s = p_ext_s;
        endcase
`endif
        // {sum, Q} after the arithmetic shift is the new {P, Q}; its low bits are the product.
        prod_s = RW'({sum_s, q_q[QW-1:SH]});
    end

    // Next-state and datapath control for IDLE -> CALC -> DONE.
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        p_d      = p_q;
        q_d      = q_q;
        q1_d     = q1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CALC;
                    m_d     = {{2{a_msb_s}}, bus.a_value};
                    p_d     = {PW{1'b0}};
                    q_d     = QW'(bus.b_value);
                    q1_d    = 1'b0;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_CALC: begin
                p_d  = sum_s[SW-1:SH];
                q_d  = {sum_s[SH-1:0], q_q[QW-1:SH]};
                q1_d = q_q[SH-1];
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = ST_DONE;
                    result_d = prod_s;
                    done_d   = 1'b1;
                    cnt_d    = {CW{1'b0}};
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!_reset) begin
            state_q  <= ST_IDLE;
            m_q      <= {PW{1'b0}};
            p_q      <= {PW{1'b0}};
            q_q      <= {QW{1'b0}};
            q1_q     <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            result_q <= {RW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            p_q      <= p_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench for booth_multiplier_param: signed 8-bit, unsigned 8-bit and signed 16-bit
// instances run side by side against an arithmetic reference model.
module tb_booth_multiplier_param;
`ifdef BOOTH_RADIX4_EN
    localparam bit R4 = 1'b1;
`else
    localparam bit R4 = 1'b0;
`endif
    localparam int LOOP = 22;

    logic clock;
    logic _reset;

    booth_multiplier_param_if #(.WIDTH(8))  if_s8  ();
    booth_multiplier_param_if #(.WIDTH(8))  if_u8  ();
    booth_multiplier_param_if #(.WIDTH(16)) if_s16 ();

    booth_multiplier_param #(.WIDTH(8),  .SIGNED(1)) u_s8  (.clock(clock), ._reset(_reset), .bus(if_s8));
    booth_multiplier_param #(.WIDTH(8),  .SIGNED(0)) u_u8  (.clock(clock), ._reset(_reset), .bus(if_u8));
    booth_multiplier_param #(.WIDTH(16), .SIGNED(1)) u_s16 (.clock(clock), ._reset(_reset), .bus(if_s16));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          nn[3];
    string       nm[3];
    logic        busy_v[3];
    logic        done_v[3];
    logic [63:0] res_v[3];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                             input int w, input bit sgn);
        longint      sa;
        longint      sb;
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a & mask);
        sb = longint'(b & mask);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(sa * sb) & mask;
    endfunction

    function automatic int latency(input int w, input bit sgn);
        int e;
        e = sgn ? 0 : (R4 ? 2 : 1);
        return R4 ? (w + e) / 2 : (w + e);
    endfunction

    task automatic sample_all();
        busy_v[0] = if_s8.busy;  done_v[0] = if_s8.done;  res_v[0] = 64'(if_s8.result);
        busy_v[1] = if_u8.busy;  done_v[1] = if_u8.done;  res_v[1] = 64'(if_u8.result);
        busy_v[2] = if_s16.busy; done_v[2] = if_s16.done; res_v[2] = 64'(if_s16.result);
    endtask

    task automatic set_start(input logic v);
        if_s8.start = v;
        if_u8.start = v;
        if_s16.start = v;
    endtask

    task automatic set_ops(input logic [7:0] a8, input logic [7:0] b8,
                           input logic [15:0] a16, input logic [15:0] b16);
        if_s8.a_value  = a8;  if_s8.b_value  = b8;
        if_u8.a_value  = a8;  if_u8.b_value  = b8;
        if_s16.a_value = a16; if_s16.b_value = b16;
    endtask

    // One operation on all three instances; optionally re-pulse start with other operands mid-calculation.
    task automatic run_op(input string tag, input logic [7:0] a8, input logic [7:0] b8,
                          input logic [15:0] a16, input logic [15:0] b16, input bit repulse);
        logic [63:0] exp_v[3];
        int          dcyc[3];
        int          dcnt[3];
        int          bcnt[3];
        exp_v[0] = ref_prod(64'(a8), 64'(b8), 8, 1'b1);
        exp_v[1] = ref_prod(64'(a8), 64'(b8), 8, 1'b0);
        exp_v[2] = ref_prod(64'(a16), 64'(b16), 16, 1'b1);
        set_ops(a8, b8, a16, b16);
        set_start(1'b1);
        @(posedge clock);
        @(negedge clock);
        set_start(1'b0);
        set_ops(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
        sample_all();
        for (int i = 0; i < 3; i++) begin
            dcyc[i] = -1;
            dcnt[i] = 0;
            bcnt[i] = busy_v[i] ? 1 : 0;
        end
        for (int cyc = 1; cyc <= LOOP; cyc++) begin
            if (repulse && cyc == 3) begin
                set_ops(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
                set_start(1'b1);
            end else if (repulse && cyc == 4) begin
                set_start(1'b0);
            end
            @(posedge clock);
            @(negedge clock);
            sample_all();
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) bcnt[i]++;
                if (done_v[i]) begin
                    dcnt[i]++;
                    dcyc[i] = cyc;
                    check_val($sformatf("%s_%s_result", tag, nm[i]), res_v[i], exp_v[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s_%s_done_pulses", tag, nm[i]), 64'(dcnt[i]), 64'd1);
            check_val($sformatf("%s_%s_done_cycle", tag, nm[i]), 64'(dcyc[i]), 64'(nn[i]));
            check_val($sformatf("%s_%s_busy_cycles", tag, nm[i]), 64'(bcnt[i]), 64'(nn[i] + 1));
            check_val($sformatf("%s_%s_result_held", tag, nm[i]), res_v[i], exp_v[i]);
        end
    endtask

    task automatic reset_mid_op();
        set_ops(8'h5A, 8'hC3, 16'h1234, 16'hF00D);
        set_start(1'b1);
        @(posedge clock);
        @(negedge clock);
        set_start(1'b0);
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
        end
        _reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        _reset = 1'b1;
        sample_all();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("midrst_%s_busy", nm[i]), 64'(busy_v[i]), 64'd0);
            check_val($sformatf("midrst_%s_done", nm[i]), 64'(done_v[i]), 64'd0);
            check_val($sformatf("midrst_%s_result", nm[i]), res_v[i], 64'd0);
        end
        repeat (LOOP) @(posedge clock);
        @(negedge clock);
        sample_all();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("midrst_%s_stays_idle", nm[i]), 64'({busy_v[i], done_v[i]}), 64'd0);
        end
    endtask

    // start held high on the signed 8-bit instance while the operands alternate after every product.
    task automatic held_start();
        logic [63:0] expq[$];
        logic [7:0]  pa[2];
        logic [7:0]  pb[2];
        logic [63:0] want;
        int          seen;
        int          last;
        int          gap;
        int          sel;
        bit          prev_done;
        for (int k = 0; k < 2; k++) begin
            pa[k] = 8'($urandom);
            pb[k] = 8'($urandom);
        end
        sel = 0;
        if_s8.a_value = pa[0];
        if_s8.b_value = pb[0];
        expq.push_back(ref_prod(64'(pa[0]), 64'(pb[0]), 8, 1'b1));
        if_s8.start = 1'b1;
        seen = 0;
        last = -1;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 6 * (nn[0] + 2) + 2; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            sample_all();
            if (prev_done) check_val("held_done_width", 64'(done_v[0]), 64'd0);
            prev_done = done_v[0];
            if (done_v[0]) begin
                seen++;
                if (expq.size() > 0) want = expq.pop_front();
                else want = 64'hFFFF_FFFF_FFFF_FFFF;
                check_val("held_result", res_v[0], want);
                if (last >= 0) begin
                    gap = cyc - last;
                    check_val("held_spacing", 64'((gap == nn[0] + 1) || (gap == nn[0] + 2)), 64'd1);
                end
                last = cyc;
                sel = 1 - sel;
                if_s8.a_value = pa[sel];
                if_s8.b_value = pb[sel];
                expq.push_back(ref_prod(64'(pa[sel]), 64'(pb[sel]), 8, 1'b1));
            end
        end
        if_s8.start = 1'b0;
        check_val("held_product_count", 64'(seen >= 5), 64'd1);
        repeat (LOOP) @(posedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nm[0] = "s8";
        nm[1] = "u8";
        nm[2] = "s16";
        nn[0] = latency(8, 1'b1);
        nn[1] = latency(8, 1'b0);
        nn[2] = latency(16, 1'b1);
        _reset = 1'b0;
        set_start(1'b0);
        set_ops(8'h00, 8'h00, 16'h0000, 16'h0000);
        repeat (3) @(posedge clock);
        @(negedge clock);
        sample_all();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset_%s_busy", nm[i]), 64'(busy_v[i]), 64'd0);
            check_val($sformatf("reset_%s_done", nm[i]), 64'(done_v[i]), 64'd0);
            check_val($sformatf("reset_%s_result", nm[i]), res_v[i], 64'd0);
        end
        _reset = 1'b1;
        @(negedge clock);

        run_op("d_01xF8", 8'h01, 8'hF8, 16'h8000, 16'h7FFF, 1'b0);
        run_op("d_80x80", 8'h80, 8'h80, 16'h8000, 16'h8000, 1'b0);
        run_op("d_7Fx80", 8'h7F, 8'h80, 16'h7FFF, 16'h7FFF, 1'b0);
        run_op("d_00xA5", 8'h00, 8'hA5, 16'h0000, 16'hA5A5, 1'b0);
        run_op("d_FFxFF", 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0);
        for (int r = 0; r < 16; r++) begin
            run_op($sformatf("rnd%0d", r), 8'($urandom), 8'($urandom),
                   16'($urandom), 16'($urandom), 1'b0);
        end
        run_op("repulse", 8'hB7, 8'h39, 16'hC0DE, 16'h0F0F, 1'b1);
        reset_mid_op();
        run_op("post_rst", 8'h9C, 8'h6B, 16'h4321, 16'h8765, 1'b0);
        held_start();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
